// File: rtl/oms_pkg.sv
// Shared helpers for the OMS address mapper: width math, APC coding, zero code.
// Latency: n/a (functions only, elaborated into combinational logic).
// Backpressure: n/a.
package oms_pkg;

  // Ceiling log2, used for elaboration-time width math.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // APC coding of a w-bit word (w <= 32). Bits w-2..0 carry x'.
  // Bit w-1 and anything above it pass straight through, and callers drop them.
  // When xm=1, x' is the magnitude field unchanged.
  // When xm=0, every bit above the lowest set bit is flipped, which is the
  // two's-complement negation of the magnitude field.
  function automatic logic [31:0] apc_code(input logic [31:0] x, input int w);
    logic [31:0] r;
    logic        xm;
    logic        seen;
    xm   = x[5'(w - 1)];
    r    = x;
    seen = x[0];
    for (int k = 1; k < 32; k++) begin
      if (k <= w - 2) begin
        r[5'(k)] = x[5'(k)] ^ (~xm & seen);
        seen     = seen | x[5'(k)];
      end
    end
    return r;
  endfunction

  // LUT address reserved for an all-zero input word.
  function automatic int zero_addr(input int w);
    return 1 << (w - 2);
  endfunction

endpackage

// File: rtl/oms_tz_norm.sv
// Trailing-zero count and right-normalise of an N-bit word to its odd part.
// Latency: 0 cycles (single-level combinational, no iterative search).
// Backpressure: none, this block is pure logic.
module oms_tz_norm #(
  parameter int N    = 4,
  parameter int SH_W = 2
) (
  input  logic [N-1:0]    x_i,
  output logic [SH_W-1:0] shift_o,
  output logic [N-1:0]    norm_o,
  output logic            is_zero_o
);

  // Isolate the lowest set bit. This is one-hot, or all zero for x_i == 0.
  logic [N-1:0] low1;
  assign low1 = x_i & (-x_i);

  // One-hot to binary: shift bit b is set when the set position has bit b set.
  for (genvar b = 0; b < SH_W; b++) begin : g_enc
    logic [N-1:0] mask;
    for (genvar i = 0; i < N; i++) begin : g_mask
      assign mask[i] = (((i >> b) & 1) != 0);
    end
    assign shift_o[b] = |(low1 & mask);
  end

  assign norm_o    = x_i >> shift_o;
  assign is_zero_o = ~|x_i;

endmodule

// File: rtl/oms_addr_map_pipe.sv
// Maps a multiplier word to an OMS LUT address, normalising shift, control bit and zero flag.
// Latency: 2 cycles (APC-code register, then normalise register). Full rate when unstalled.
// Backpressure: 2-deep elastic stall pipeline. in_ready drops only when both stages hold data and out_ready is low.
module oms_addr_map_pipe
  import oms_pkg::*;
#(
  parameter int W      = 5,
  parameter int ADDR_W = W - 1,
  parameter int SH_W   = (clog2(W - 1) > 1) ? clog2(W - 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [SH_W-1:0]   shift,
  output logic              ctrl,
  output logic              zero
);

  localparam int XW = W - 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_addr(W));

  // Stage 1: APC-coded word plus the captured control and zero bits.
  logic          s1_valid_q, s1_valid_d;
  logic [XW-1:0] s1_xp_q,    s1_xp_d;
  logic          s1_xm_q,    s1_xm_d;
  logic          s1_xz_q,    s1_xz_d;

  // Output stage.
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [SH_W-1:0]   shift_q,     shift_d;
  logic              ctrl_q,      ctrl_d;
  logic              zero_q,      zero_d;

  logic          s2_adv;
  logic          accept;
  logic          s1_adv;
  logic [SH_W-1:0] tz_shift;
  logic [XW-1:0]   tz_norm;
  logic            tz_zero;

  oms_tz_norm #(
    .N    (XW),
    .SH_W (SH_W)
  ) u_tz_norm (
    .x_i       (s1_xp_q),
    .shift_o   (tz_shift),
    .norm_o    (tz_norm),
    .is_zero_o (tz_zero)
  );

  assign s2_adv   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready;
  assign s1_adv   = s1_valid_q & s2_adv;

  // Next-state logic: load s1 on accept, and move s1 into the output stage when the output can take it.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_xp_d     = s1_xp_q;
    s1_xm_d     = s1_xm_q;
    s1_xz_d     = s1_xz_q;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    ctrl_d      = ctrl_q;
    zero_d      = zero_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_xp_d    = XW'(apc_code(32'(x), W));
      s1_xm_d    = x[W-1];
      s1_xz_d    = (x == '0);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      ctrl_d      = s1_xm_q;
      if (tz_zero) begin
        shift_d = '0;
        zero_d  = 1'b1;
        addr_d  = s1_xz_q ? ZERO_ADDR : '0;
      end else begin
        shift_d = tz_shift;
        zero_d  = 1'b0;
        addr_d  = ADDR_W'(tz_norm >> 1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers. Synchronous reset drops any in-flight words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_xp_q     <= '0;
      s1_xm_q     <= 1'b0;
      s1_xz_q     <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      shift_q     <= '0;
      ctrl_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_xp_q     <= s1_xp_d;
      s1_xm_q     <= s1_xm_d;
      s1_xz_q     <= s1_xz_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign addr      = addr_q;
  assign shift     = shift_q;
  assign ctrl      = ctrl_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_oms_addr_map_pipe.sv
// Bench for oms_addr_map_pipe: three instances at W=5, W=6 and W=8, checked against a scoreboard.
// Latency: expects a result two cycles after the word is presented; back-pressure and reset are directed.
// Backpressure: out_ready is driven directly, and in_ready is checked against the in-flight count.
module tb_oms_addr_map_pipe;

  typedef struct {
    int addr;
    int shift;
    int ctrl;
    int zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] ir;
  logic [2:0] ov;
  logic       ordy;
  logic [7:0] xs;
  logic [2:0] ctl;
  logic [2:0] zr;
  logic [3:0] addr5;
  logic [4:0] addr6;
  logic [6:0] addr8;
  logic [1:0] sh5;
  logic [2:0] sh6;
  logic [2:0] sh8;

  int   cmp  = 0;
  int   errs = 0;
  exp_t q[3][$];
  int   nfl[3] = '{0, 0, 0};
  int   dlv[3] = '{0, 0, 0};

  oms_addr_map_pipe #(.W(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .x(xs[4:0]),
    .out_valid(ov[0]), .out_ready(ordy), .addr(addr5), .shift(sh5), .ctrl(ctl[0]), .zero(zr[0])
  );
  oms_addr_map_pipe #(.W(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .x(xs[5:0]),
    .out_valid(ov[1]), .out_ready(ordy), .addr(addr6), .shift(sh6), .ctrl(ctl[1]), .zero(zr[1])
  );
  oms_addr_map_pipe #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .x(xs),
    .out_valid(ov[2]), .out_ready(ordy), .addr(addr8), .shift(sh8), .ctrl(ctl[2]), .zero(zr[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, errors so far=%0d", errs);
    $fatal(1, "watchdog expired");
  end

  function automatic int w_of(input int d);
    return (d == 0) ? 5 : ((d == 1) ? 6 : 8);
  endfunction

  // Reference model built from the arithmetic form: negate the magnitude unless xm is set, then strip trailing zeros.
  function automatic exp_t model(input int w, input logic [7:0] xin);
    exp_t e;
    int   xv, mask, m, xp;
    xv      = int'(xin) & ((1 << w) - 1);
    mask    = (1 << (w - 1)) - 1;
    m       = xv & mask;
    e.ctrl  = (xv >> (w - 1)) & 1;
    xp      = (e.ctrl != 0) ? m : ((-m) & mask);
    e.shift = 0;
    if (xp == 0) begin
      e.zero = 1;
      e.addr = (xv == 0) ? (1 << (w - 2)) : 0;
    end else begin
      e.zero = 0;
      while (((xp >> e.shift) & 1) == 0) e.shift++;
      e.addr = (xp >> e.shift) >> 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] addr_of(input int d);
    case (d)
      0:       return 32'(addr5);
      1:       return 32'(addr6);
      default: return 32'(addr8);
    endcase
  endfunction

  function automatic logic [31:0] sh_of(input int d);
    case (d)
      0:       return 32'(sh5);
      1:       return 32'(sh6);
      default: return 32'(sh8);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    cmp++;
    assert (got === expv)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Scoreboard: pop and compare on each output transfer, hold-check stalled outputs, push on accept, check in_ready.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q[d].delete();
        nfl[d] = 0;
      end else begin
        chk($sformatf("in_ready_d%0d", d), {31'b0, ir[d]}, {31'b0, (nfl[d] < 2) || ordy});
        if (ov[d] && !ordy && q[d].size() > 0) begin
          chk($sformatf("hold_addr_d%0d", d), addr_of(d), q[d][0].addr);
          chk($sformatf("hold_shift_d%0d", d), sh_of(d), q[d][0].shift);
        end
        if (ov[d] && ordy) begin
          if (q[d].size() == 0) begin
            chk($sformatf("unexpected_out_d%0d", d), {31'b0, ov[d]}, 32'd0);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("addr_d%0d", d),  addr_of(d),        e.addr);
            chk($sformatf("shift_d%0d", d), sh_of(d),          e.shift);
            chk($sformatf("ctrl_d%0d", d),  {31'b0, ctl[d]},   e.ctrl);
            chk($sformatf("zero_d%0d", d),  {31'b0, zr[d]},    e.zero);
          end
          nfl[d]--;
          dlv[d]++;
        end
        if (iv[d] && ir[d]) begin
          q[d].push_back(model(w_of(d), xs));
          nfl[d]++;
        end
      end
    end
  end

  // One clock of stimulus. Call it at posedge+1. It returns whether the word was accepted.
  task automatic cyc(input int d, input bit v, input logic [7:0] xv, input bit r, output bit acc);
    iv   = 3'(v) << d;
    xs   = xv;
    ordy = r;
    @(negedge clk);
    acc = v && ir[d];
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] xv, input bit r);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) cyc(d, 1'b1, xv, r, acc);
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain(input int d);
    bit acc;
    for (int i = 0; i < 64 && (q[d].size() != 0 || ov[d]); i++) cyc(d, 1'b0, 8'h00, 1'b1, acc);
    chk($sformatf("drain_empty_d%0d", d), 32'(q[d].size()), 32'd0);
  endtask

  initial begin
    bit         acc;
    int         dl;
    int         nw;
    bit         pend;
    logic [7:0] cur;
    logic [7:0] sx[4];
    exp_t       lit[4];
    logic [7:0] bw[4];

    rst_n = 1'b0;
    iv    = '0;
    xs    = '0;
    ordy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {29'b0, ov},  32'd0);
    chk("rst_in_ready",  {29'b0, ir},  32'd7);
    chk("rst_addr5",     addr_of(0),   32'd0);
    chk("rst_shift8",    sh_of(2),     32'd0);
    chk("rst_ctrl_zero", {26'b0, ctl, zr}, 32'd0);
    rst_n = 1'b1;

    // Directed stream at W=5, out_ready held high.
    sx[0] = 8'b000_00110; lit[0] = '{2, 1, 0, 0};
    sx[1] = 8'b000_10110; lit[1] = '{1, 1, 1, 0};
    sx[2] = 8'b000_00001; lit[2] = '{7, 0, 0, 0};
    sx[3] = 8'b000_11000; lit[3] = '{0, 3, 1, 0};
    for (int i = 0; i < 6; i++) begin
      cyc(0, i < 4, (i < 4) ? sx[i] : 8'h00, 1'b1, acc);
      if (i == 0) begin
        chk("lat_not_yet", {31'b0, ov[0]}, 32'd0);
      end else if (i <= 4) begin
        chk($sformatf("stream%0d_valid", i - 1), {31'b0, ov[0]},  32'd1);
        chk($sformatf("stream%0d_addr",  i - 1), addr_of(0),      lit[i-1].addr);
        chk($sformatf("stream%0d_shift", i - 1), sh_of(0),        lit[i-1].shift);
        chk($sformatf("stream%0d_ctrl",  i - 1), {31'b0, ctl[0]}, lit[i-1].ctrl);
      end else begin
        chk("stream_done_valid", {31'b0, ov[0]}, 32'd0);
      end
    end

    // Zero codes: x=0 maps to the reserved address, and x=10000 maps to address 0 with zero set.
    cyc(0, 1'b1, 8'h00, 1'b1, acc);
    cyc(0, 1'b1, 8'h10, 1'b1, acc);
    chk("x0_addr",  addr_of(0),      32'd8);
    chk("x0_zero",  {31'b0, zr[0]},  32'd1);
    chk("x0_shift", sh_of(0),        32'd0);
    cyc(0, 1'b0, 8'h00, 1'b1, acc);
    chk("x10_addr", addr_of(0),      32'd0);
    chk("x10_zero", {31'b0, zr[0]},  32'd1);
    chk("x10_ctrl", {31'b0, ctl[0]}, 32'd1);
    drain(0);

    // Back-pressure: only two words fit while out_ready is low.
    bw[0] = 8'h03; bw[1] = 8'h15; bw[2] = 8'h0C; bw[3] = 8'h1F;
    dl = dlv[0];
    cyc(0, 1'b1, bw[0], 1'b0, acc);
    chk("bp_acc0", {31'b0, acc}, 32'd1);
    cyc(0, 1'b1, bw[1], 1'b0, acc);
    chk("bp_acc1", {31'b0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, bw[2], 1'b0, acc);
      chk("bp_refused", {31'b0, acc}, 32'd0);
      chk("bp_hold_valid", {31'b0, ov[0]}, 32'd1);
      chk("bp_hold_addr", addr_of(0), model(5, bw[0]).addr);
    end
    send(0, bw[2], 1'b1);
    send(0, bw[3], 1'b1);
    drain(0);
    chk("bp_count", 32'(dlv[0] - dl), 32'd4);

    // Reset with two words in flight discards both.
    cyc(0, 1'b1, 8'h07, 1'b0, acc);
    cyc(0, 1'b1, 8'h19, 1'b0, acc);
    rst_n = 1'b0;
    cyc(0, 1'b0, 8'h00, 1'b0, acc);
    rst_n = 1'b1;
    chk("mrst_out_valid", {31'b0, ov[0]}, 32'd0);
    chk("mrst_addr",      addr_of(0),     32'd0);
    chk("mrst_shift",     sh_of(0),       32'd0);
    chk("mrst_in_ready",  {31'b0, ir[0]}, 32'd1);
    dl = dlv[0];
    repeat (6) cyc(0, 1'b0, 8'h00, 1'b1, acc);
    chk("mrst_no_stale", 32'(dlv[0] - dl), 32'd0);

    // W=8 exhaustive sweep, then the boundary cases.
    for (int v = 0; v < 256; v++) begin
      cyc(2, 1'b1, 8'(v), 1'b1, acc);
      chk("w8_sweep_accept", {31'b0, acc}, 32'd1);
    end
    drain(2);
    cyc(2, 1'b1, 8'h00, 1'b1, acc);
    cyc(2, 1'b1, 8'hC0, 1'b1, acc);
    chk("w8_x0_addr", addr_of(2),     32'd64);
    chk("w8_x0_zero", {31'b0, zr[2]}, 32'd1);
    cyc(2, 1'b0, 8'h00, 1'b1, acc);
    chk("w8_max_shift", sh_of(2),       32'd6);
    chk("w8_max_addr",  addr_of(2),     32'd0);
    chk("w8_max_ctrl",  {31'b0, ctl[2]}, 32'd1);
    drain(2);

    // Random valid/ready traffic at W=5 and W=6. The source holds each offered word until it is taken.
    for (int d = 0; d < 2; d++) begin
      nw   = 0;
      pend = 1'b0;
      cur  = 8'h00;
      for (int c = 0; c < 30000 && nw < 5000; c++) begin
        if (!pend) begin
          pend = ($urandom_range(0, 99) < 70);
          cur  = 8'($urandom);
        end
        cyc(d, pend, cur, $urandom_range(0, 99) < 65, acc);
        if (acc) begin
          pend = 1'b0;
          nw++;
        end
      end
      chk($sformatf("rand_words_d%0d", d), 32'(nw), 32'd5000);
      drain(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

// File: doc/oms_addr_map_pipe.md
Name: oms_addr_map_pipe

Overview:
- Parametrised, pipelined successor to the combinational OMS address mapper.
- Maps a W-bit multiplier word to an odd-multiple LUT address, a normalising shift count, a sign/control bit and a zero flag.
- Sits between the operand source and the OMS LUT + barrel shifter in the LUT multiplier datapath.
- Valid/ready handshake on both sides; 2-cycle latency.

Parameters:
- W, 5, input word width; legal W >= 3.
- ADDR_W, W-1, LUT address width: odd-multiple index plus the zero code.
- SH_W, max(1, clog2(W-1)), shift-count width; maximum shift is W-2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- x  in  W  multiplier word; x[W-1] is the APC control bit xm
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- addr  out  ADDR_W  OMS LUT address
- shift  out  SH_W  left-shift amount to apply to the LUT output
- ctrl  out  1  registered xm (add/subtract select downstream)
- zero  out  1  intermediate word x' was zero

Behaviour:
- Reset is synchronous, active-low. When rst_n=0 at a clock edge:
  - all valid flags clear;
  - addr, shift, ctrl and zero go to 0;
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight words; no output is produced for them.
- Stage 1 (APC coding), registered into s1:
  - x'[0] = x[0].
  - for k = 1..W-2: x'[k] = x[k] XOR (~xm AND OR(x[k-1:0])).
  - Equivalently: x' = xm ? x[W-2:0] : (-x[W-2:0]) mod 2^(W-1).
  - Also capture xm and xz = (x == 0).
- Stage 2 (odd normalisation), registered into outputs:
  - if x' != 0: shift = count of trailing zeros of x'; x'' = x' >> shift; addr = x'' >> 1; zero = 0.
  - if x' == 0: shift = 0; zero = 1; addr = xz ? (1 << (W-2)) : 0.
  - ctrl = stage-1 xm.
- Handshake (stall pipeline, no bubbles lost):
  - s2_adv = ~out_valid | out_ready.
  - in_ready = ~s1_valid | s2_adv.
  - Input accepted when in_valid & in_ready.
  - s1 → output moves when s1_valid & s2_adv.
  - out_valid clears when out_ready=1 and s1 holds nothing to advance.
- Throughput: 1 word/cycle when out_ready=1 continuously.
- Latency: accepted at edge N → out_valid=1 after edge N+2, provided there is no back-pressure.
- Output stability: while out_valid=1 and out_ready=0, addr, shift, ctrl and zero hold stable. No input is lost or duplicated.
- Simultaneous accept and advance in the same cycle is legal. The pipeline behaves as a 2-deep elastic buffer.
- The stage-2 normaliser is a priority trailing-zero detector. No iterative loop is allowed; the result must be single-cycle combinational.

Decomposition:
- Shared package oms_pkg:
  - function clog2;
  - function apc_code(x, W) implementing the stage-1 equations;
  - localparam zero code ZERO_ADDR = 1 << (W-2).
- One sub-module, oms_tz_norm: parametrised trailing-zero count and right-normalise of a (W-1)-bit word. Outputs shift, x'' and is_zero.
- All handshake and pipeline registers stay in the top module.

Test Plan:
- W=5, out_ready=1, stream x = 00110, 10110, 00001, 11000 →
  - 00110: addr=2, shift=1, ctrl=0, zero=0
  - 10110: addr=1, shift=1, ctrl=1
  - 00001: addr=7, shift=0, ctrl=0
  - 11000: addr=0, shift=3, ctrl=1
  - Results arrive in order, one per cycle, starting 2 cycles after the first accept.
- W=5, x=00000 → addr=8, zero=1, shift=0. Then x=10000 → addr=0, zero=1, ctrl=1.
- Back-pressure: feed 4 words with out_ready=0 → in_ready drops after 2 words are accepted and outputs hold stable. Release out_ready → all 4 results drain in order with no loss or duplication.
- Reset: pulse rst_n=0 for 1 cycle with 2 words in flight → next cycle out_valid=0, addr=0, shift=0, in_ready=1; no stale result appears afterwards.
- W=8 exhaustive: all 256 x values vs a reference model → addr, shift, zero and ctrl match. Check addr=64 for x=0 and max shift=6 (e.g. x=11000000, x'=1000000).
- Random in_valid/out_ready toggling, 10k words, W=5 and W=6 → scoreboard order and values match the model; in_ready equals ~s1_valid | s2_adv every cycle.
